f_pc_fetch: RTL

- Fetch-side consumer of the next-PC value produced in D stage.
- Holds the architectural F_PC register and launches one instruction-memory read per PC over a req/ready handshake.
- Presents the fetched word and its valid flag to the F/D pipeline register.
- Obeys the hazard unit's F_stall and flags instruction-address exceptions (AdEL) for bad targets.

---
 rtl/f_pc_fetch_pkg.sv | 17 +
 rtl/f_addr_check.sv | 24 ++
 rtl/f_pc_fetch.sv | 103 ++++++++++
 3 files changed

// File: rtl/f_pc_fetch_pkg.sv
// Shared definitions for the fetch stage: PC bounds, the nop word and the
// fetch-state encoding.
package f_pc_fetch_pkg;

  localparam logic [31:0] PC_INIT_DEF  = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_6FFC;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_REQ  = 2'd0,
    ST_DONE = 2'd1,
    ST_EXC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/f_addr_check.sv
// Combinational instruction-address legality check: flags a word address that
// is misaligned or outside [PC_INIT, PC_LIMIT].
module f_addr_check
  import f_pc_fetch_pkg::*;
#(
  parameter logic [31:0] PC_INIT  = PC_INIT_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic [31:0] addr,
  output logic        bad
);

  logic misaligned;
  logic below_range;
  logic above_range;

  always_comb begin
    misaligned  = (addr[1:0] != 2'b00);
    below_range = (addr < PC_INIT);
    above_range = (addr > PC_LIMIT);
    bad         = misaligned || below_range || above_range;
  end

endmodule

// File: rtl/f_pc_fetch.sv
// Fetch stage: owns F_PC, issues one instruction-memory read per PC and
// buffers the returned word (or a nop plus AdEL) for the F/D register.
module f_pc_fetch
  import f_pc_fetch_pkg::*;
#(
  parameter logic [31:0] PC_INIT  = PC_INIT_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_stall,
  input  logic [31:0] D_NPC_PCnext,
  output logic        F_imem_req,
  output logic [31:0] F_imem_addr,
  input  logic        F_imem_ready,
  input  logic [31:0] F_imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_instr_valid,
  output logic        F_excAdEL
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        exc_q;

  logic npc_bad;
  logic accept;
  logic advance;

  f_addr_check #(
    .PC_INIT  (PC_INIT),
    .PC_LIMIT (PC_LIMIT)
  ) u_npc_check (
    .addr (D_NPC_PCnext),
    .bad  (npc_bad)
  );

  // Request is gated by reset so an in-flight read is withdrawn the moment
  // reset asserts, without waiting for a clock edge.
  assign F_imem_req  = (state_q == ST_REQ) && reset;
  assign F_imem_addr = pc_q;
  assign accept      = F_imem_req && F_imem_ready;
  assign advance     = (state_q != ST_REQ) && !F_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (accept) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_EXC: begin
        if (!F_stall) begin
          state_d = npc_bad ? ST_EXC : ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // Stall only matters once the fetch has finished; an accepted read always
  // lands in the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_INIT;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else if (accept) begin
      instr_q <= F_imem_rdata;
      valid_q <= 1'b1;
    end else if (advance) begin
      pc_q    <= D_NPC_PCnext;
      valid_q <= npc_bad;
      exc_q   <= npc_bad;
      if (npc_bad) begin
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign F_PC          = pc_q;
  assign F_instr       = instr_q;
  assign F_instr_valid = valid_q;
  assign F_excAdEL     = exc_q;

endmodule
